// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch and the
// memory stage. The data side wins ties because it belongs to the older
// instruction. pipe_stall freezes the whole pipeline until every request
// raised in the current pipeline cycle has been served.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1    // ram_en to ram_rdata valid, 1..15
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,

   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,

   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,

   output logic              pipe_stall,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   // WAIT always lasts at least one cycle, so the counter starts at LATENCY-1.
   localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

   state_t      state_q;
   state_t      state_d;
   logic        grant_dm_q;   // 1 = data side owns the current access
   logic        we_q;
   logic [3:0]  cnt_q;
   logic        if_served_q;
   logic        dm_served_q;

   logic        eff_if;
   logic        eff_dm;
   logic        wait_done;

   // A side already served while the pipeline is still frozen must not be
   // granted again, otherwise a finished store would be replayed.
   assign eff_dm    = dm_req & ~dm_served_q;
   assign eff_if    = if_req & ~if_served_q;
   assign wait_done = (state_q == S_WAIT) && (cnt_q == 4'd0);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and per-state strobes
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d  = state_q;
      ram_en   = 1'b0;
      if_ready = 1'b0;
      dm_ready = 1'b0;
      case (state_q)
         S_IDLE:  if (eff_dm || eff_if) state_d = S_ISSUE;
         S_ISSUE: begin
            ram_en  = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
         S_DONE: begin
            if_ready = ~grant_dm_q;
            dm_ready =  grant_dm_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram_we     = ram_en & we_q;
   assign busy       = (state_q != S_IDLE);
   assign pipe_stall = (if_req & ~(if_served_q | if_ready)) |
                       (dm_req & ~(dm_served_q | dm_ready));

   // Request latch in IDLE and wait-counter load/countdown
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_dm_q <= 1'b0;
         we_q       <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         cnt_q      <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (eff_dm) begin
                  grant_dm_q <= 1'b1;
                  we_q       <= dm_we;
                  ram_addr   <= dm_addr;
                  ram_wdata  <= dm_wdata;
               end else if (eff_if) begin
                  grant_dm_q <= 1'b0;
                  we_q       <= 1'b0;
                  ram_addr   <= if_addr;
               end
            end
            S_ISSUE: cnt_q <= WAIT_INIT;
            S_WAIT:  if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            default: ;
         endcase
      end
   end

   // Read data capture on the last WAIT cycle; stores leave dm_rdata alone
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_rdata <= '0;
         dm_rdata <= '0;
      end else if (wait_done) begin
         if (!grant_dm_q)        if_rdata <= ram_rdata;
         else if (!we_q)         dm_rdata <= ram_rdata;
      end
   end

   // Served flags: remember completed sides until the pipeline advances
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_served_q <= 1'b0;
         dm_served_q <= 1'b0;
      end else if (!pipe_stall) begin
         if_served_q <= 1'b0;
         dm_served_q <= 1'b0;
      end else if (state_q == S_DONE) begin
         if (grant_dm_q) dm_served_q <= 1'b1;
         else            if_served_q <= 1'b1;
      end
   end

endmodule
